// File: rtl/bidir_port_ctrl_pkg.sv
// Shared definitions for the half-duplex port sequencer: state encodings and
// default link geometry.
package bidir_port_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_TURN_CYCLES = 2;
    localparam int DEF_MAX_BURST   = 4;

    localparam logic [1:0] ST_RX      = 2'd0;
    localparam logic [1:0] ST_TURN_TX = 2'd1;
    localparam logic [1:0] ST_TX      = 2'd2;
    localparam logic [1:0] ST_TURN_RX = 2'd3;

endpackage

// File: rtl/bidir_port_ctrl_if.sv
// Local-side transmit/receive handshake of the port sequencer.
interface bidir_port_ctrl_if import bidir_port_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    modport master (output tx_valid, tx_data, input tx_ready, rx_data, rx_valid);
    modport slave  (input tx_valid, tx_data, output tx_ready, rx_data, rx_valid);

endinterface

// File: rtl/bidir_port_ctrl_turn_timer.sv
// Down-counter timing a bus turnaround; done is high during the final cycle
// of the loaded interval.
module turn_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg <= CW'(1));

endmodule

// File: rtl/bidir_port_ctrl.sv
// Direction sequencer for one end of a half-duplex tristate link: receives
// peer words, or turns the bus around with dead cycles and sends a capped burst.
module bidir_port_ctrl import bidir_port_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             peer_busy,
    input  logic             peer_strobe,
    output logic             tx_strobe,
    output logic             drive_en,
    output logic             own_busy,
    output logic             contention,
    bidir_port_ctrl_if.slave host
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);

    logic [1:0]       state_reg, state_next;
    logic [BW-1:0]    burst_reg;
    logic [WIDTH-1:0] out_q_reg, rx_data_reg;
    logic             drive_en_reg, tx_strobe_reg, rx_valid_reg;
    logic             own_busy_reg, contention_reg;
    logic             handshake, start_tx, turn_load, turn_en, turn_done;

    assign host.tx_ready = (state_reg == ST_TX) && (burst_reg < BURST_CAP);
    assign handshake     = host.tx_valid && host.tx_ready;
    // An incoming peer word always beats our own request to turn around.
    assign start_tx      = host.tx_valid && !peer_busy && !peer_strobe;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RX:      if (start_tx)   state_next = ST_TURN_TX;
            ST_TURN_TX: if (turn_done)  state_next = ST_TX;
            // No handshake means the word on the bus now is the last one.
            ST_TX:      if (!handshake) state_next = ST_TURN_RX;
            ST_TURN_RX: if (turn_done)  state_next = ST_RX;
            default:                    state_next = ST_RX;
        endcase
    end

    assign turn_load = ((state_reg == ST_RX) && (state_next == ST_TURN_TX)) ||
                       ((state_reg == ST_TX) && (state_next == ST_TURN_RX));
    assign turn_en   = (state_reg == ST_TURN_TX) || (state_reg == ST_TURN_RX);

    turn_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
        .clk  (clk),
        .rst  (rst),
        .load (turn_load),
        .en   (turn_en),
        .done (turn_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RX;
            burst_reg      <= '0;
            out_q_reg      <= '0;
            rx_data_reg    <= '0;
            drive_en_reg   <= 1'b0;
            tx_strobe_reg  <= 1'b0;
            rx_valid_reg   <= 1'b0;
            own_busy_reg   <= 1'b0;
            contention_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drive_en_reg   <= (state_next == ST_TX);
            own_busy_reg   <= (state_next != ST_RX);
            tx_strobe_reg  <= handshake;
            rx_valid_reg   <= (state_reg == ST_RX) && peer_strobe;
            contention_reg <= own_busy_reg && peer_strobe;
            if ((state_reg == ST_RX) && peer_strobe) begin
                rx_data_reg <= bus;
            end
            if (handshake) begin
                out_q_reg <= host.tx_data;
            end
            if (state_reg == ST_TURN_TX) begin
                burst_reg <= '0;
            end else if (handshake) begin
                burst_reg <= burst_reg + 1'b1;
            end
        end
    end

    assign bus           = drive_en_reg ? out_q_reg : {WIDTH{1'bz}};
    assign drive_en      = drive_en_reg;
    assign tx_strobe     = tx_strobe_reg;
    assign own_busy      = own_busy_reg;
    assign contention    = contention_reg;
    assign host.rx_data  = rx_data_reg;
    assign host.rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Randomised bench for bidir_port_ctrl: per-cycle output traces compared with
// a timing model derived from burst sizes and turnaround length.
module tb_bidir_port_ctrl;

    localparam int W  = 8;
    localparam int T  = 2;
    localparam int MB = 4;
    localparam int NC = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wire  [W-1:0] bus;
    logic         peer_en;
    logic [W-1:0] peer_word;
    assign bus = peer_en ? peer_word : {W{1'bz}};

    logic peer_busy, peer_strobe, tx_strobe, drive_en, own_busy, contention;

    bidir_port_ctrl_if #(.WIDTH(W)) host ();

    bidir_port_ctrl #(.WIDTH(W), .TURN_CYCLES(T), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .peer_busy   (peer_busy),
        .peer_strobe (peer_strobe),
        .tx_strobe   (tx_strobe),
        .drive_en    (drive_en),
        .own_busy    (own_busy),
        .contention  (contention),
        .host        (host)
    );

    int checks = 0;
    int errors = 0;

    // flag bits: [4] drive_en [3] own_busy [2] tx_strobe [1] contention [0] rx_valid
    logic [4:0]   log_flags[NC];
    logic [4:0]   exp_flags[NC];
    logic [W-1:0] log_bus[NC];
    logic [W-1:0] exp_bus[NC];
    logic [W-1:0] txq[$];
    logic [W-1:0] sent[$];

    // Streams the queue through the handshake for ncyc cycles, logging outputs.
    task automatic run_trace(input int ps);
        bit hs;
        for (int c = 0; c < NC; c++) begin
            peer_strobe   = (c == ps);
            host.tx_valid = (txq.size() != 0);
            host.tx_data  = (txq.size() != 0) ? txq[0] : '0;
            @(negedge clk);
            log_flags[c] = {drive_en, own_busy, tx_strobe, contention, host.rx_valid};
            log_bus[c]   = bus;
            hs = host.tx_valid && host.tx_ready;
            @(posedge clk);
            #1;
            if (hs) void'(txq.pop_front());
        end
        peer_strobe   = 1'b0;
        host.tx_valid = 1'b0;
    endtask

    // Cycle 0 is the first cycle tx_valid is sampled in an idle port.
    task automatic build_expect(input int ps);
        int start = 0;
        int rem   = sent.size();
        int widx  = 0;
        int m;
        for (int c = 0; c < NC; c++) begin
            exp_flags[c] = '0;
            exp_bus[c]   = '0;
        end
        while (rem > 0) begin
            m = (rem > MB) ? MB : rem;
            for (int c = start + 1; c <= start + 2*T + m + 1; c++)
                if (c < NC) exp_flags[c][3] = 1'b1;
            for (int c = start + T + 1; c <= start + T + m + 1; c++)
                if (c < NC) exp_flags[c][4] = 1'b1;
            for (int j = 0; j < m; j++) begin
                if (start + T + 2 + j < NC) begin
                    exp_flags[start + T + 2 + j][2] = 1'b1;
                    exp_bus[start + T + 2 + j]      = sent[widx];
                end
                widx++;
            end
            rem   -= m;
            start += 2*T + m + 2;
        end
        if (ps >= 0 && ps + 1 < NC && exp_flags[ps][3]) exp_flags[ps + 1][1] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({drive_en, own_busy, tx_strobe, contention, host.rx_valid, host.tx_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {drive_en, own_busy, tx_strobe, contention, host.rx_valid, host.tx_ready});
        end
        checks++;
        if (host.rx_data !== '0) begin
            errors++;
            $display("FAIL reset_rx_data got %h exp 00", host.rx_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_rx(input logic [W-1:0] word);
        peer_en = 1'b1; peer_word = word; peer_strobe = 1'b1;
        @(posedge clk);
        #1 peer_en = 1'b0; peer_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (host.rx_valid !== 1'b1 || host.rx_data !== word || drive_en !== 1'b0) begin
            errors++;
            $display("FAIL rx_capture got v=%b d=%h de=%b exp v=1 d=%h de=0",
                     host.rx_valid, host.rx_data, drive_en, word);
        end
        @(negedge clk);
        checks++;
        if (host.rx_valid !== 1'b0 || host.rx_data !== word || own_busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_pulse got v=%b d=%h ob=%b exp v=0 d=%h ob=0",
                     host.rx_valid, host.rx_data, own_busy, word);
        end
        @(posedge clk);
        #1;
        $display("rx: word %h", word);
    endtask

    task automatic test_tx(input int n, input bit fixed);
        txq.delete();
        for (int i = 0; i < n; i++)
            txq.push_back(fixed ? W'(8'h11 * (i + 1)) : W'($urandom));
        sent = txq;
        build_expect(-1);
        run_trace(-1);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (log_flags[c] !== exp_flags[c]) begin
                errors++;
                $display("FAIL tx_flags n=%0d cyc %0d got %b exp %b", n, c, log_flags[c], exp_flags[c]);
            end
            if (exp_flags[c][2]) begin
                checks++;
                if (log_bus[c] !== exp_bus[c]) begin
                    errors++;
                    $display("FAIL tx_bus n=%0d cyc %0d got %h exp %h", n, c, log_bus[c], exp_bus[c]);
                end
            end
        end
        $display("tx: burst of %0d words", n);
    endtask

    task automatic test_contention();
        int n  = $urandom_range(1, 4);
        int ps = $urandom_range(1, 2*T + n + 1);
        txq.delete();
        for (int i = 0; i < n; i++) txq.push_back(W'($urandom));
        sent = txq;
        build_expect(ps);
        run_trace(ps);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (log_flags[c] !== exp_flags[c]) begin
                errors++;
                $display("FAIL contention_flags cyc %0d got %b exp %b", c, log_flags[c], exp_flags[c]);
            end
            if (exp_flags[c][2]) begin
                checks++;
                if (log_bus[c] !== exp_bus[c]) begin
                    errors++;
                    $display("FAIL contention_bus cyc %0d got %h exp %h", c, log_bus[c], exp_bus[c]);
                end
            end
        end
        $display("contention: n=%0d strobe at cycle %0d", n, ps);
    endtask

    task automatic test_priority();
        logic [W-1:0] word = W'($urandom);
        int ob_cnt = 0, de_cnt = 0, st_cnt = 0;
        txq.delete();
        txq.push_back(W'($urandom));
        host.tx_valid = 1'b1; host.tx_data = txq[0];
        peer_en = 1'b1; peer_word = word; peer_strobe = 1'b1;
        @(posedge clk);
        #1 peer_en = 1'b0; peer_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (host.rx_valid !== 1'b1 || host.rx_data !== word || own_busy !== 1'b0) begin
            errors++;
            $display("FAIL priority_capture got v=%b d=%h ob=%b exp v=1 d=%h ob=0",
                     host.rx_valid, host.rx_data, own_busy, word);
        end
        @(negedge clk);
        checks++;
        if (own_busy !== 1'b1) begin
            errors++;
            $display("FAIL priority_request got ob=%b exp 1", own_busy);
        end
        @(posedge clk);
        #1;
        run_trace(-1);
        // peer_busy blocks the turnaround indefinitely
        peer_busy = 1'b1; host.tx_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (own_busy !== 1'b0 || drive_en !== 1'b0) begin
                errors++;
                $display("FAIL peer_busy_hold cyc %0d got ob=%b de=%b exp 0 0", c, own_busy, drive_en);
            end
        end
        // release, then withdraw the request before TX entry: empty ownership
        @(posedge clk);
        #1 peer_busy = 1'b0;
        @(posedge clk);
        #1 host.tx_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ob_cnt += int'(own_busy);
            de_cnt += int'(drive_en);
            st_cnt += int'(tx_strobe);
        end
        checks++;
        if (ob_cnt != 2*T + 1 || de_cnt != 1 || st_cnt != 0) begin
            errors++;
            $display("FAIL empty_tx got ob=%0d de=%0d st=%0d exp ob=%0d de=1 st=0",
                     ob_cnt, de_cnt, st_cnt, 2*T + 1);
        end
        @(posedge clk);
        #1;
        $display("priority: capture word %h, peer_busy hold, empty ownership", word);
    endtask

    task automatic test_reset_mid_tx();
        bit found = 1'b0;
        bit hs;
        txq.delete();
        for (int i = 0; i < 3; i++) txq.push_back(W'($urandom));
        for (int c = 0; c < 20 && !found; c++) begin
            host.tx_valid = (txq.size() != 0);
            host.tx_data  = (txq.size() != 0) ? txq[0] : '0;
            @(negedge clk);
            hs = host.tx_valid && host.tx_ready;
            if (drive_en && tx_strobe) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (hs) void'(txq.pop_front());
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_tx_reach got no strobed word within 20 cycles exp strobe");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (drive_en !== 1'b0 || own_busy !== 1'b0 || tx_strobe !== 1'b0) begin
            errors++;
            $display("FAIL mid_tx_reset got de=%b ob=%b st=%b exp 0 0 0", drive_en, own_busy, tx_strobe);
        end
        rst = 1'b0; host.tx_valid = 1'b0; txq.delete();
        repeat (2) @(posedge clk);
        #1;
        $display("reset_mid_tx: done");
    endtask

    initial begin
        rst = 1'b1; peer_en = 1'b0; peer_word = '0; peer_busy = 1'b0; peer_strobe = 1'b0;
        host.tx_valid = 1'b0; host.tx_data = '0;
        test_reset();
        test_rx(8'hA5);
        test_rx(W'($urandom));
        test_tx(3, 1'b1);
        for (int i = 0; i < 3; i++) test_tx($urandom_range(1, 4), 1'b0);
        test_tx(6, 1'b1);
        test_tx($urandom_range(5, 8), 1'b0);
        test_priority();
        for (int i = 0; i < 3; i++) test_contention();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
